// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w19.sv
// IJTAG-accessible override controller for the 19-bit functional/IJTAG data mux.
// The scan register loads a shadow override word and a persistent or timed one-shot mode.
module firebird7_in_gate1_tessent_data_mux_ctrl_w19 #(
    parameter int WIDTH       = 19,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_in
);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_hold
            $error("HOLD_CYCLES must be in 1..2^CNT_W-1");
        end
    endgenerate

    localparam int SR_W = WIDTH + 2;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        TIMED  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_nxt;
    logic              upd;
    logic              sr_enable;
    logic              sr_oneshot;

    assign upd        = ijtag_sel & ijtag_ue;
    assign sr_enable  = sr[SR_W-1];
    assign sr_oneshot = sr[SR_W-2];
    assign ijtag_so   = sr[0];

    // Scan register: capture has priority over shift; nothing moves unless selected.
    always_comb begin
        sr_nxt = sr;
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                sr_nxt = {ijtag_select, (state == TIMED), functional_data_in};
            end else if (ijtag_se) begin
                sr_nxt = {ijtag_si, sr[SR_W-1:1]};
            end
        end
    end

    // Update decodes the pre-edge register; an update always beats countdown expiry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (upd) begin
            if (!sr_enable) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else if (!sr_oneshot) begin
                state_nxt = ACTIVE;
                cnt_nxt   = '0;
            end else begin
                state_nxt = TIMED;
                cnt_nxt   = HOLD_LOAD;
            end
        end else if (state == TIMED) begin
            if (cnt == CNT_W'(1)) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            sr            <= '0;
            ijtag_data_in <= '0;
            cnt           <= '0;
            state         <= IDLE;
            ijtag_select  <= 1'b0;
        end else begin
            sr           <= sr_nxt;
            cnt          <= cnt_nxt;
            state        <= state_nxt;
            // Select is kept as its own flop so the mux sees a clean registered control.
            ijtag_select <= (state_nxt != IDLE);
            if (upd) begin
                ijtag_data_in <= sr[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl_w19.sv
// Directed bench for the IJTAG data-mux override controller.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl_w19;

    localparam int WIDTH = 19;
    localparam int HOLD  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             sel, ce, se, ue, si;
    logic             so;
    logic [WIDTH-1:0] fdata;
    logic             select;
    logic [WIDTH-1:0] data;

    int n_chk  = 0;
    int n_fail = 0;

    firebird7_in_gate1_tessent_data_mux_ctrl_w19 #(
        .WIDTH(WIDTH), .HOLD_CYCLES(HOLD), .CNT_W(8)
    ) dut (
        .ijtag_tck          (clk),
        .ijtag_reset        (rst),
        .ijtag_sel          (sel),
        .ijtag_ce           (ce),
        .ijtag_se           (se),
        .ijtag_ue           (ue),
        .ijtag_si           (si),
        .ijtag_so           (so),
        .functional_data_in (fdata),
        .ijtag_select       (select),
        .ijtag_data_in      (data)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_word(input logic [20:0] w);
        sel = 1'b1;
        se  = 1'b1;
        for (int i = 0; i < 21; i++) begin
            si = w[i];
            tick();
        end
        se = 1'b0;
        si = 1'b0;
    endtask

    task automatic pulse_update();
        sel = 1'b1;
        ue  = 1'b1;
        tick();
        ue  = 1'b0;
    endtask

    task automatic pulse_capture();
        sel = 1'b1;
        ce  = 1'b1;
        tick();
        ce  = 1'b0;
    endtask

    initial begin
        logic [20:0] obs;
        int hi;

        rst = 1'b1; sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
        fdata = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk_eq("rst_select", select, 0);
        chk_eq("rst_data", data, 0);
        chk_eq("rst_so", so, 0);

        // Capture in IDLE, then shift out LSB first
        fdata = 19'h5A5A5;
        pulse_capture();
        chk_eq("cap_idle_sr", dut.sr, 32'h005A5A5);
        obs[0] = so;
        se = 1'b1;
        si = 1'b0;
        for (int i = 1; i < 21; i++) begin
            tick();
            obs[i] = so;
        end
        tick();
        se = 1'b0;
        chk_eq("shift_out_word", obs, 32'h005A5A5);
        chk_eq("shift_out_tail", so, 0);

        // Persistent override
        shift_word(21'h17FFFF);
        pulse_update();
        chk_eq("act_select", select, 1);
        chk_eq("act_data", data, 32'h7FFFF);
        for (int i = 0; i < 1000; i++) tick();
        chk_eq("act_hold_1000", select, 1);
        shift_word(21'h07FFFF);
        pulse_update();
        chk_eq("release_select", select, 0);
        chk_eq("release_data", data, 32'h7FFFF);

        // One-shot: high for exactly HOLD cycles
        shift_word(21'h192345);
        pulse_update();
        chk_eq("timed_data", data, 32'h12345);
        hi = select ? 1 : 0;
        for (int c = 1; c < 40; c++) begin
            tick();
            if (select) hi++;
        end
        chk_eq("timed_len", hi, HOLD);
        chk_eq("timed_end_select", select, 0);

        // Capture during TIMED reports ENABLE=1, ONESHOT=1
        pulse_update();
        tick();
        tick();
        fdata = 19'h0ABCD;
        pulse_capture();
        chk_eq("cap_timed_flags", dut.sr[20:19], 2'b11);
        chk_eq("cap_timed_data", dut.sr[18:0], 32'h0ABCD);
        for (int c = 0; c < 30; c++) tick();
        chk_eq("cap_timed_expired", select, 0);

        // Reload 10 cycles in
        shift_word(21'h192345);
        ue = 1'b1;
        tick();
        ue = 1'b0;
        hi = select ? 1 : 0;
        for (int c = 1; c < 60; c++) begin
            ue = (c == 10);
            tick();
            ue = 1'b0;
            if (select) hi++;
        end
        chk_eq("reload_len", hi, 26);

        // Update on the expiry edge wins
        ue = 1'b1;
        tick();
        ue = 1'b0;
        hi = select ? 1 : 0;
        for (int c = 1; c < 60; c++) begin
            ue = (c == HOLD);
            tick();
            ue = 1'b0;
            if (select) hi++;
        end
        chk_eq("expiry_update_len", hi, 32);
        chk_eq("expiry_update_end", select, 0);

        // Deselected segment ignores scan controls; countdown keeps running
        pulse_update();
        hi = select ? 1 : 0;
        sel = 1'b0;
        for (int c = 1; c < 40; c++) begin
            ce    = c[0];
            se    = c[1];
            ue    = c[2];
            si    = c[3];
            fdata = 19'h7FFFF ^ 19'(c);
            tick();
            if (select) hi++;
        end
        ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
        chk_eq("nosel_len", hi, HOLD);
        chk_eq("nosel_sr", dut.sr, 32'h192345);
        chk_eq("nosel_data", data, 32'h12345);
        chk_eq("nosel_select", select, 0);

        // Reset in ACTIVE with every scan control asserted
        shift_word(21'h17FFFF);
        pulse_update();
        chk_eq("pre_rst_select", select, 1);
        rst = 1'b1; sel = 1'b1; ce = 1'b1; se = 1'b1; ue = 1'b1; si = 1'b1;
        tick();
        rst = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
        chk_eq("mid_rst_select", select, 0);
        chk_eq("mid_rst_data", data, 0);
        chk_eq("mid_rst_so", so, 0);
        chk_eq("mid_rst_sr", dut.sr, 0);
        chk_eq("mid_rst_cnt", dut.cnt, 0);
        tick();
        chk_eq("post_rst_select", select, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/firebird7_in_gate1_tessent_data_mux_ctrl_w19.md
# firebird7_in_gate1_tessent_data_mux_ctrl_w19

IJTAG-accessible controller that drives the select and override data of the 19-bit functional/IJTAG data mux in `firebird7_in_gate1`. A 21-bit scan register is shifted through the IJTAG network. On update it loads a shadow override word and one of two override modes: persistent, or timed one-shot that auto-releases after a programmable number of cycles. Capture samples the live functional data and override status, so the chain can observe what the mux would pass.

## Interface
Parameters
- `WIDTH`, 19: override data width, equal to the mux width.
- `HOLD_CYCLES`, 16: one-shot override duration in clock cycles. Legal range is 1..2^CNT_W−1; 0 is an elaboration error.
- `CNT_W`, 8: hold counter width.

Ports (clock and reset first)
- `ijtag_tck`, in, 1: the single clock; all state updates on the rising edge.
- `ijtag_reset`, in, 1: reset, synchronous and active-high.
- `ijtag_sel`, in, 1: segment selected; it gates capture, shift and update.
- `ijtag_ce`, in, 1: capture enable.
- `ijtag_se`, in, 1: shift enable.
- `ijtag_ue`, in, 1: update enable.
- `ijtag_si`, in, 1: scan in.
- `ijtag_so`, out, 1: scan out, equal to `sr[0]`.
- `functional_data_in`, in, WIDTH: the functional data observed by the mux; used for capture only.
- `ijtag_select`, out, 1: drives the mux select.
- `ijtag_data_in`, out, WIDTH: shadow override data, drives the mux IJTAG input.

## Operation
Scan register `sr[WIDTH+1:0]` (21 bits) has three fields:
- `sr[20]` ENABLE
- `sr[19]` ONESHOT
- `sr[18:0]` DATA

Register actions, each only when `ijtag_sel`=1:
- Capture (`ijtag_ce`=1): `sr <= {ijtag_select, state==TIMED, functional_data_in}`.
- Shift (`ijtag_se`=1, `ijtag_ce`=0): `sr <= {ijtag_si, sr[20:1]}`. The LSB is shifted out first.
- Capture and shift asserted together: capture wins.
- Update (`ijtag_ue`=1) acts on the pre-edge `sr` and is independent of capture/shift in the same cycle:
  - `ijtag_data_in <= sr[18:0]` unconditionally.
  - State transition per the FSM below.
- `ijtag_sel`=0: `sr`, the shadow and the FSM take no scan/update action. The TIMED countdown keeps running.

FSM, states IDLE / ACTIVE / TIMED, `ijtag_select` = (state != IDLE):
- Update with ENABLE=0: go to IDLE from any state; clear the counter.
- Update with ENABLE=1, ONESHOT=0: go to ACTIVE from any state.
- Update with ENABLE=1, ONESHOT=1: go to TIMED and load the counter with HOLD_CYCLES. This also applies from TIMED, which reloads (restarts) the countdown.
- In TIMED with no update: decrement the counter each cycle. When the counter is 1, the next state is IDLE and the counter becomes 0.
- Update and counter expiry in the same cycle: the update wins.
- ACTIVE persists until an update with ENABLE=0, or reset.

Release behaviour:
- `ijtag_data_in` holds its last updated value after release.
- Only `ijtag_select` drops on release.

Reset (synchronous, while `ijtag_reset`=1):
- `sr`=0, `ijtag_data_in`=0, counter=0, state=IDLE.
- Therefore `ijtag_select`=0 and `ijtag_so`=0.
- Reset overrides every scan operation in the same cycle.
- Reset in ACTIVE/TIMED releases the mux at the next edge.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `ijtag_so` changes only on a shift or capture edge.
- Update at edge k: `ijtag_select` and `ijtag_data_in` take their new values after edge k, in the same cycle.
- TIMED: `ijtag_select`=1 for exactly HOLD_CYCLES cycles after the update edge, then 0.
- A full scan load takes 21 shift cycles, followed by 1 update cycle.

## Test plan
- Reset then idle: `ijtag_select`=0, `ijtag_data_in`=0, `ijtag_so`=0. A capture with `functional_data_in`=19'h5A5A5 followed by 21 shifts must shift out 19'h5A5A5 LSB-first, then 0, then 0.
- Shift in {1,0,19'h7FFFF} then update: `ijtag_select`=1 after the update edge, `ijtag_data_in`=19'h7FFFF. It stays set for 1000 cycles. A subsequent update with ENABLE=0 gives `ijtag_select`=0 while `ijtag_data_in` stays 19'h7FFFF.
- With HOLD_CYCLES=16, shift in {1,1,19'h12345} then update: `ijtag_select` high for exactly 16 cycles. A capture during TIMED must return bits[20:19]=2'b11.
- Reload in TIMED: issue a second one-shot update 10 cycles in. Select must stay high for 16 cycles from the second update (26 total). Also cover an update landing on the expiry cycle: the update wins.
- With `ijtag_sel`=0 and ce/se/ue toggling: `sr`, shadow and state are unchanged, and a running TIMED countdown still expires on schedule.
- Assert `ijtag_reset` for 1 cycle during ACTIVE and during a shift with `ijtag_ce`=1 in the same cycle: all state is 0, and `ijtag_select`=0 at the next edge.
